// File: rtl/cnn_layer_accel_weight_seq_reader.sv
// Read sequencer for the AWE weight-sequence tables: it issues table reads and streams the
// returned word pairs through a 3-entry valid/ready FIFO.
module cnn_layer_accel_weight_seq_reader #(
  parameter int unsigned C_RDADDR_WIDTH   = 5,
  parameter int unsigned C_SEQ_DOUT_WIDTH = 16,
  parameter int unsigned C_PASS_WIDTH     = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [C_RDADDR_WIDTH-1:0]   cfg_start_addr,
  input  logic [C_RDADDR_WIDTH:0]     cfg_num_values,
  input  logic [C_PASS_WIDTH-1:0]     cfg_num_passes,
  output logic [C_RDADDR_WIDTH-1:0]   rdAddr,
  output logic                        rden,
  input  logic [C_SEQ_DOUT_WIDTH-1:0] seq_dout0,
  input  logic [C_SEQ_DOUT_WIDTH-1:0] seq_dout1,
  output logic                        seq_valid,
  input  logic                        seq_ready,
  output logic [C_SEQ_DOUT_WIDTH-1:0] seq_data0,
  output logic [C_SEQ_DOUT_WIDTH-1:0] seq_data1,
  output logic                        seq_last_val,
  output logic                        seq_last,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned AW = C_RDADDR_WIDTH;
  localparam int unsigned DW = C_SEQ_DOUT_WIDTH;
  localparam int unsigned PW = C_PASS_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e        r_state, w_state_d;
  logic [AW-1:0] r_addr, r_start_addr;
  logic [AW:0]   r_val_cnt, r_num_values;
  logic [PW-1:0] r_pass_cnt, r_num_passes;
  logic          r_in_flight, r_fl_last_val, r_fl_last;

  logic [DW-1:0] r_d0 [0:2];
  logic [DW-1:0] r_d1 [0:2];
  logic          r_lv [0:2];
  logic          r_l  [0:2];
  logic [1:0]    r_wr_ptr, r_rd_ptr, r_count;

  logic       w_cfg_zero, w_issue, w_last_val_idx, w_last_pass, w_issue_last;
  logic       w_push, w_pop;
  logic [1:0] w_occ, w_count_d, w_wr_ptr_inc, w_rd_ptr_inc;

  assign w_cfg_zero     = (cfg_num_values == '0) || (cfg_num_passes == '0);
  // Reserve a slot for every read still in the table pipeline so the FIFO never overflows.
  assign w_occ          = r_count + {1'b0, r_in_flight};
  assign w_issue        = (r_state == StIssue) && (w_occ < 2'd3);
  assign w_last_val_idx = (r_val_cnt == r_num_values - 1'b1);
  assign w_last_pass    = (r_pass_cnt == r_num_passes - 1'b1);
  assign w_issue_last   = w_issue && w_last_val_idx && w_last_pass;
  assign w_push         = r_in_flight;
  assign w_pop          = (r_count != 2'd0) && seq_ready;
  assign w_wr_ptr_inc   = (r_wr_ptr == 2'd2) ? 2'd0 : r_wr_ptr + 2'd1;
  assign w_rd_ptr_inc   = (r_rd_ptr == 2'd2) ? 2'd0 : r_rd_ptr + 2'd1;

  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - 2'd1;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (start) w_state_d = w_cfg_zero ? StDone : StIssue;
      StIssue: if (w_issue_last) w_state_d = StDrain;
      StDrain: if (w_count_d == 2'd0) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr        <= '0;
      r_start_addr  <= '0;
      r_val_cnt     <= '0;
      r_num_values  <= '0;
      r_pass_cnt    <= '0;
      r_num_passes  <= '0;
      r_in_flight   <= 1'b0;
      r_fl_last_val <= 1'b0;
      r_fl_last     <= 1'b0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      for (int i = 0; i < 3; i++) begin
        r_d0[i] <= '0;
        r_d1[i] <= '0;
        r_lv[i] <= 1'b0;
        r_l[i]  <= 1'b0;
      end
    end else begin
      r_in_flight   <= w_issue;
      r_fl_last_val <= w_issue && w_last_val_idx;
      r_fl_last     <= w_issue_last;

      if (r_state == StIdle && start && !w_cfg_zero) begin
        r_start_addr <= cfg_start_addr;
        r_num_values <= cfg_num_values;
        r_num_passes <= cfg_num_passes;
        r_addr       <= cfg_start_addr;
        r_val_cnt    <= '0;
        r_pass_cnt   <= '0;
      end else if (w_issue) begin
        if (w_last_val_idx) begin
          r_val_cnt  <= '0;
          r_pass_cnt <= r_pass_cnt + 1'b1;
          r_addr     <= r_start_addr;
        end else begin
          r_val_cnt <= r_val_cnt + 1'b1;
          r_addr    <= r_addr + 1'b1;
        end
      end

      if (w_push) begin
        r_d0[r_wr_ptr] <= seq_dout0;
        r_d1[r_wr_ptr] <= seq_dout1;
        r_lv[r_wr_ptr] <= r_fl_last_val;
        r_l[r_wr_ptr]  <= r_fl_last;
        r_wr_ptr       <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_d;
    end
  end

  assign rdAddr       = r_addr;
  assign rden         = w_issue;
  assign seq_valid    = (r_count != 2'd0);
  assign seq_data0    = r_d0[r_rd_ptr];
  assign seq_data1    = r_d1[r_rd_ptr];
  assign seq_last_val = r_lv[r_rd_ptr];
  assign seq_last     = r_l[r_rd_ptr];
  assign busy         = (r_state == StIssue) || (r_state == StDrain);
  assign done         = (r_state == StDone);

endmodule

// File: tb/tb_cnn_layer_accel_weight_seq_reader.sv
// Randomized bench: a command-level reference model predicts every read address, every output
// pair with its tags, and the busy/done windows.
module tb_cnn_layer_accel_weight_seq_reader;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 16;
  localparam int unsigned PW    = 8;
  localparam int unsigned NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_start_addr = '0;
  logic [AW:0]   cfg_num_values = '0;
  logic [PW-1:0] cfg_num_passes = '0;
  logic [AW-1:0] rdAddr;
  logic          rden;
  logic [DW-1:0] seq_dout0 = '0;
  logic [DW-1:0] seq_dout1 = '0;
  logic          seq_valid;
  logic          seq_ready = 1'b1;
  logic [DW-1:0] seq_data0, seq_data1;
  logic          seq_last_val, seq_last, busy, done;

  cnn_layer_accel_weight_seq_reader #(
    .C_RDADDR_WIDTH  (AW),
    .C_SEQ_DOUT_WIDTH(DW),
    .C_PASS_WIDTH    (PW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_start_addr(cfg_start_addr),
    .cfg_num_values(cfg_num_values),
    .cfg_num_passes(cfg_num_passes),
    .rdAddr        (rdAddr),
    .rden          (rden),
    .seq_dout0     (seq_dout0),
    .seq_dout1     (seq_dout1),
    .seq_valid     (seq_valid),
    .seq_ready     (seq_ready),
    .seq_data0     (seq_data0),
    .seq_data1     (seq_data1),
    .seq_last_val  (seq_last_val),
    .seq_last      (seq_last),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic          lv;
    logic          l;
  } pair_t;

  logic [DW-1:0] tbl0 [NADDR];
  logic [DW-1:0] tbl1 [NADDR];
  pair_t         pair_q[$];
  logic [AW-1:0] addr_q[$];

  int n_chk = 0;
  int n_err = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  int m_phase = 0;     // 0: idle, 1: command running, 2: done cycle
  int m_k = 0;
  int issued = 0;
  int xfer = 0;
  bit full_speed = 1'b0;
  bit prev_hold = 1'b0;
  bit rst_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Table model: one-cycle read latency, garbage on cycles without a read.
  initial begin
    logic          r;
    logic [AW-1:0] a;
    forever begin
      @(negedge clk);
      r = rden;
      a = rdAddr;
      @(posedge clk);
      #1;
      if (r === 1'b1) begin
        seq_dout0 = tbl0[a];
        seq_dout1 = tbl1[a];
      end else begin
        seq_dout0 = DW'($urandom);
        seq_dout1 = DW'($urandom);
      end
      case (ready_mode)
        0:       seq_ready = 1'b1;
        1:       seq_ready = ($urandom_range(0, 3) != 0);
        default: seq_ready = 1'b0;
      endcase
    end
  end

  // Reference model and checker.
  initial begin
    pair_t         p;
    logic [AW-1:0] a;
    bit            last_xfer;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pair_q.delete();
        addr_q.delete();
        m_phase = 0; m_k = 0; issued = 0; xfer = 0;
        prev_hold = 1'b0; full_speed = 1'b0; rst_seen = 1'b1;
      end else begin
        if (rst_seen) begin
          chk("rst_rdaddr", rdAddr, 0);
          chk("rst_rden", rden, 0);
          chk("rst_valid", seq_valid, 0);
          chk("rst_data0", seq_data0, 0);
          chk("rst_data1", seq_data1, 0);
          chk("rst_last_val", seq_last_val, 0);
          chk("rst_last", seq_last, 0);
          chk("rst_busy", busy, 0);
          chk("rst_done", done, 0);
          rst_seen = 1'b0;
        end
        if (ready_mode != 0) full_speed = 1'b0;
        chk("busy", busy, m_phase == 1);
        chk("done", done, m_phase == 2);
        if (m_phase == 1) m_k++;
        if (m_phase == 1 && m_k == 1) chk("first_rden", rden, 1);
        if (m_phase == 1 && m_k == 2) chk("valid_early", seq_valid, 0);
        if (m_phase == 1 && m_k == 3) chk("valid_latency", seq_valid, 1);

        if (addr_q.size() == 0) begin
          chk("rden_idle", rden, 0);
        end else begin
          if (full_speed) chk("rden_rate", rden, 1);
          if (rden === 1'b1) begin
            chk("outstanding", (issued - xfer) < 3, 1);
            chk("rdaddr", rdAddr, addr_q.pop_front());
            issued++;
          end
        end

        if (prev_hold) chk("valid_hold", seq_valid, 1);
        last_xfer = 1'b0;
        if (pair_q.size() == 0) begin
          chk("valid_idle", seq_valid, 0);
        end else if (seq_valid === 1'b1) begin
          p = pair_q[0];
          chk("data0", seq_data0, p.d0);
          chk("data1", seq_data1, p.d1);
          chk("last_val", seq_last_val, p.lv);
          chk("last", seq_last, p.l);
          if (seq_ready) begin
            void'(pair_q.pop_front());
            xfer++;
            last_xfer = p.l;
          end
        end else if (full_speed && m_k >= 3) begin
          chk("valid_rate", seq_valid, 1);
        end
        prev_hold = (seq_valid === 1'b1) && !seq_ready;

        case (m_phase)
          2: m_phase = 0;
          1: if (last_xfer) m_phase = 2;
          default: begin
            if (start) begin
              if (cfg_num_values == 0 || cfg_num_passes == 0) begin
                m_phase = 2;
              end else begin
                for (int ps = 0; ps < int'(cfg_num_passes); ps++) begin
                  for (int v = 0; v < int'(cfg_num_values); v++) begin
                    a = cfg_start_addr + AW'(v);
                    addr_q.push_back(a);
                    p.d0 = tbl0[a];
                    p.d1 = tbl1[a];
                    p.lv = (v == int'(cfg_num_values) - 1);
                    p.l  = p.lv && (ps == int'(cfg_num_passes) - 1);
                    pair_q.push_back(p);
                  end
                end
                m_phase = 1; m_k = 0; issued = 0; xfer = 0;
                full_speed = (ready_mode == 0);
              end
            end
          end
        endcase
      end
    end
  end

  task automatic send_cmd(input int addr, input int nv, input int np);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_start_addr = AW'(addr);
    cfg_num_values = (AW + 1)'(nv);
    cfg_num_passes = PW'(np);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_start_addr = AW'($urandom);
    cfg_num_values = (AW + 1)'($urandom);
    cfg_num_passes = PW'($urandom);
  endtask

  // Waits for the model to return to idle; optional 10-cycle stall and a stray start pulse.
  task automatic wait_idle(input int stall_at, input bit poke);
    int saved_mode;
    saved_mode = ready_mode;
    for (int i = 0; i < 3000; i++) begin
      if (m_phase == 0) return;
      if (i == stall_at) ready_mode = 2;
      if (i == stall_at + 10) ready_mode = saved_mode;
      if (poke && i == 2) begin
        #1;
        start = 1'b1;
        cfg_num_values = 7'(3);
        cfg_num_passes = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      @(posedge clk);
    end
    chk("cmd_timeout", 0, 1);
    ready_mode = saved_mode;
  endtask

  initial begin
    int nv, np;
    for (int i = 0; i < int'(NADDR); i++) begin
      tbl0[i] = DW'($urandom);
      tbl1[i] = DW'($urandom);
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    ready_mode = 0;
    send_cmd(4, 3, 1);              wait_idle(-100, 1'b0);
    send_cmd(NADDR - 2, 4, 1);      wait_idle(-100, 1'b0);
    send_cmd(9, 2, 3);              wait_idle(-100, 1'b1);
    ready_mode = 1;
    send_cmd(1, 12, 2);             wait_idle(6, 1'b0);
    ready_mode = 0;
    send_cmd(5, 0, 3);              wait_idle(-100, 1'b0);
    send_cmd(5, 4, 0);              wait_idle(-100, 1'b0);

    // Zero-count start held into the done cycle must not launch a second command.
    @(posedge clk); #1;
    start = 1'b1; cfg_start_addr = 5'd3; cfg_num_values = 7'd0; cfg_num_passes = 8'd2;
    @(posedge clk); #1;
    cfg_num_values = 7'd3; cfg_num_passes = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(-100, 1'b0);

    // Reset in the middle of issuing, then a clean command.
    send_cmd(7, 20, 2);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    send_cmd(20, 5, 2);             wait_idle(-100, 1'b0);

    for (int c = 0; c < 30; c++) begin
      ready_mode = $urandom_range(0, 1);
      nv = ($urandom_range(0, 7) == 0) ? int'(NADDR) : $urandom_range(0, 10);
      np = $urandom_range(0, 3);
      send_cmd($urandom_range(0, NADDR - 1), nv, np);
      wait_idle(($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : -100, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
